// File: rtl/mips_pkg.sv
// Shared MIPS32 core definitions: datapath field widths, exception codes,
// and the EX->MEM exception-merge helper.
package mips_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned EXCW = 5;

    localparam logic [EXCW-1:0] EXC_NONE = 5'd0;
    localparam logic [EXCW-1:0] EXC_INT  = 5'd0;
    localparam logic [EXCW-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXCW-1:0] EXC_ADES = 5'd5;
    localparam logic [EXCW-1:0] EXC_RI   = 5'd10;
    localparam logic [EXCW-1:0] EXC_OV   = 5'd12;

    // An exception code raised in an earlier stage always beats an EX overflow.
    function automatic logic [EXCW-1:0] exc_merge(input logic [EXCW-1:0] exc,
                                                  input logic            ov);
        if (exc != EXC_NONE)
            return exc;
        else if (ov)
            return EXC_OV;
        else
            return EXC_NONE;
    endfunction

endpackage

// File: rtl/pipe_reg_em_if.sv
// EX->MEM bundle interface. The exception/delay-slot fields exist only when
// PIPE_EM_EXC_EN is defined.
interface pipe_reg_em_if;
    import mips_pkg::*;

    logic            stall;
    logic            bubble;
    logic            exc_flush;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] instr_in;
    logic [XLEN-1:0] alu_in;
    logic [XLEN-1:0] rt_in;
    logic [REGW-1:0] wreg_in;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] instr_out;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] rt_out;
    logic [REGW-1:0] wreg_out;
    logic            valid_out;
`ifdef PIPE_EM_EXC_EN
    logic            bd_in;
    logic [EXCW-1:0] exc_in;
    logic            ov_in;
    logic            bd_out;
    logic [EXCW-1:0] exc_out;
`endif

    // EX-stage / hazard-control side
    modport master (
`ifdef PIPE_EM_EXC_EN
        output bd_in, exc_in, ov_in,
        input  bd_out, exc_out,
`endif
        output stall, bubble, exc_flush, pc_in, instr_in, alu_in, rt_in, wreg_in,
        input  pc_out, instr_out, alu_out, rt_out, wreg_out, valid_out
    );

    // Pipeline register side
    modport slave (
`ifdef PIPE_EM_EXC_EN
        input  bd_in, exc_in, ov_in,
        output bd_out, exc_out,
`endif
        input  stall, bubble, exc_flush, pc_in, instr_in, alu_in, rt_in, wreg_in,
        output pc_out, instr_out, alu_out, rt_out, wreg_out, valid_out
    );

endinterface

// File: rtl/pipe_field_reg.sv
// One field of a pipeline register: async active-low reset and synchronous
// clear both load RST_VAL; clear beats hold, hold beats load.
module pipe_field_reg #(
    parameter int unsigned   W       = 32,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         hold,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Field state: reset > clear > hold > load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= RST_VAL;
        else if (clr)
            q <= RST_VAL;
        else if (!hold)
            q <= d;
    end

endmodule

// File: rtl/pipe_reg_em.sv
// EX->MEM pipeline register. Priority per edge: reset > exc_flush > stall >
// bubble > load. A bubble zeroes the bundle but keeps PC/BD so EPC stays right.
// Define PIPE_EM_EXC_EN to carry exception code / delay-slot fields and to
// enable the overflow merge with write-back suppression.
module pipe_reg_em
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    pipe_reg_em_if.slave   em
);

    logic [XLEN-1:0] instr_d;
    logic [XLEN-1:0] alu_d;
    logic [XLEN-1:0] rt_d;
    logic [REGW-1:0] wreg_d;
    logic            valid_d;
`ifdef PIPE_EM_EXC_EN
    logic [EXCW-1:0] exc_m;
    logic [EXCW-1:0] exc_d;
`endif

    // Next-bundle selection: bubble zeroes payload, exception suppresses write-back
    always_comb begin
        instr_d = em.instr_in;
        alu_d   = em.alu_in;
        rt_d    = em.rt_in;
        wreg_d  = em.wreg_in;
        valid_d = 1'b1;
`ifdef PIPE_EM_EXC_EN
        exc_m   = exc_merge(em.exc_in, em.ov_in);
        exc_d   = exc_m;
        if (exc_m != EXC_NONE)
            wreg_d = '0;
`endif
        if (em.bubble) begin
            instr_d = '0;
            alu_d   = '0;
            rt_d    = '0;
            wreg_d  = '0;
            valid_d = 1'b0;
`ifdef PIPE_EM_EXC_EN
            exc_d   = '0;
`endif
        end
    end

    pipe_field_reg #(.W(XLEN), .RST_VAL(PC_RESET)) u_pc (
        .clk(clk), .reset(reset), .clr(em.exc_flush), .hold(em.stall),
        .d(em.pc_in), .q(em.pc_out)
    );

    pipe_field_reg #(.W(XLEN), .RST_VAL('0)) u_instr (
        .clk(clk), .reset(reset), .clr(em.exc_flush), .hold(em.stall),
        .d(instr_d), .q(em.instr_out)
    );

    pipe_field_reg #(.W(XLEN), .RST_VAL('0)) u_alu (
        .clk(clk), .reset(reset), .clr(em.exc_flush), .hold(em.stall),
        .d(alu_d), .q(em.alu_out)
    );

    pipe_field_reg #(.W(XLEN), .RST_VAL('0)) u_rt (
        .clk(clk), .reset(reset), .clr(em.exc_flush), .hold(em.stall),
        .d(rt_d), .q(em.rt_out)
    );

    pipe_field_reg #(.W(REGW), .RST_VAL('0)) u_wreg (
        .clk(clk), .reset(reset), .clr(em.exc_flush), .hold(em.stall),
        .d(wreg_d), .q(em.wreg_out)
    );

    pipe_field_reg #(.W(1), .RST_VAL(1'b0)) u_valid (
        .clk(clk), .reset(reset), .clr(em.exc_flush), .hold(em.stall),
        .d(valid_d), .q(em.valid_out)
    );

`ifdef PIPE_EM_EXC_EN
    pipe_field_reg #(.W(1), .RST_VAL(1'b0)) u_bd (
        .clk(clk), .reset(reset), .clr(em.exc_flush), .hold(em.stall),
        .d(em.bd_in), .q(em.bd_out)
    );

    pipe_field_reg #(.W(EXCW), .RST_VAL('0)) u_exc (
        .clk(clk), .reset(reset), .clr(em.exc_flush), .hold(em.stall),
        .d(exc_d), .q(em.exc_out)
    );
`endif

endmodule

// File: doc/pipe_reg_em.md
# pipe_reg_em

EX→MEM pipeline register for the five-stage MIPS32 core, directly upstream of the MEM→WB PC register. Captures the full EX-stage instruction bundle (PC, instruction, ALU result, store data, destination register, exception code, delay-slot flag) on each clock. Supports hazard stall (hold), bubble insertion that preserves PC/BD for correct EPC, and global exception flush.

## Interface
Parameters:
- `PC_RESET` — 32'h0000_0000 — value loaded into `pc_out` on reset and on `exc_flush`.

Ports:
- `clk` input 1 — single clock; all state updates on rising edge.
- `reset` input 1 — asynchronous, active-low reset.
- `stall` input 1 — hold all outputs unchanged this cycle.
- `bubble` input 1 — load a NOP bubble but keep `pc_in`/`bd_in`.
- `exc_flush` input 1 — exception/eret entry; clear entire register.
- `pc_in` input 32 — EX-stage PC.
- `instr_in` input 32 — EX-stage instruction word.
- `alu_in` input 32 — ALU result / memory address.
- `rt_in` input 32 — forwarded rt value (store data).
- `wreg_in` input 5 — destination register number.
- `bd_in` input 1 — instruction sits in a branch delay slot.
- `exc_in` input 5 — exception code collected through EX (0 = none).
- `ov_in` input 1 — ALU arithmetic overflow on a trapping op.
- `pc_out`, `instr_out`, `alu_out`, `rt_out` output 32 — registered bundle.
- `wreg_out` output 5; `bd_out` output 1; `exc_out` output 5.
- `valid_out` output 1 — bundle is a real instruction (not bubble/flush).

## Operation
- Update priority per edge: reset (async) > `exc_flush` > `stall` > `bubble` > normal load.
- Reset (`reset`=0, async): `pc_out`=PC_RESET, all other outputs 0, `valid_out`=0.
- `exc_flush`: same values as reset, applied synchronously; overrides `stall` and `bubble`.
- `stall` (no flush): every output holds its value, including `valid_out`.
- `bubble`: `pc_out`←`pc_in`, `bd_out`←`bd_in`; `instr_out`, `alu_out`, `rt_out`, `wreg_out`, `exc_out` ← 0; `valid_out`←0.
- Normal load: all fields copy inputs; `valid_out`←1.
- Exception merge on normal load: `exc_out` ← `exc_in` if `exc_in`≠0, else 12 (Ov) if `ov_in`, else 0. Earlier-stage code always wins.
- `wreg_out` forced to 0 on normal load whenever merged exception ≠0 (faulting instruction never writes back).
- No arithmetic beyond the merge; widths pass through unchanged.

## Timing
- Latency exactly 1 cycle input→output; outputs are pure flops, no combinational input→output path.
- Reset deassertion takes effect at first rising edge after `reset` returns high; outputs stay at reset values until then.
- `stall` and `bubble` both high: `stall` wins (hold).
- `exc_flush` during `stall`: flush wins, register cleared that edge; next edge resumes normal priority.
- Back-to-back bubbles keep tracking `pc_in` each cycle, so `pc_out` is never stale during a bubble train.

## Configuration
- `PIPE_EM_EXC_EN` defined: `exc_in`, `ov_in`, `bd_in`, `exc_out`, `bd_out` present; merge and wreg suppression active.
- Undefined: those ports removed, `exc_flush` still present (clears bundle), no Ov generation, `wreg_out` always copies `wreg_in` on load.

## Structure
- Shared package `mips_pkg`: ExcCode constants (EXC_NONE=0, EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12), field widths (XLEN=32, REGW=5, EXCW=5).
- One sub-module `pipe_field_reg` (parameterised width, reset value, hold, clear-to-value, load) instantiated per field; merge logic stays in the top.

## Test plan
- Reset held low mid-run with `pc_out`=32'h0000_3010 → all outputs 0, `pc_out`=0 immediately (before next edge).
- Load pc_in=32'h3000, instr_in=32'h0000_0820, wreg_in=1 → next cycle same values, `valid_out`=1, `exc_out`=0.
- `stall`=1 for 3 cycles while inputs change → outputs frozen at prior bundle; `stall`&`bubble` both 1 → still frozen.
- `bubble`=1, pc_in=32'h3008, bd_in=1 → `pc_out`=32'h3008, `bd_out`=1, `instr_out`=0, `wreg_out`=0, `valid_out`=0.
- exc_in=0, ov_in=1, wreg_in=8 → `exc_out`=12, `wreg_out`=0; exc_in=4, ov_in=1 → `exc_out`=4.
- `exc_flush`=1 with `stall`=1 → all outputs 0, `pc_out`=PC_RESET, `valid_out`=0 next cycle.
